// File: rtl/sdram_bridge_pkg.sv
// ---------------------------------------------------------------------------
// sdram_bridge_pkg
// Shared definitions for the CPU-to-SDRAM command bridge: default clock and
// refresh parameters, the bridge FSM state encoding, the refresh debt limit
// and the byte-merge helper used by read-modify-write.
// No ports (package).
// ---------------------------------------------------------------------------
package sdram_bridge_pkg;

    // Defaults match the 48 MHz main clock and a 15 us refresh interval
    localparam int CLK_HZ_DEFAULT     = 48_000_000;
    localparam int REFRESH_US_DEFAULT = 15;
    localparam int ADDR_W_DEFAULT     = 23;

    // Refresh debt is a 2-bit saturating count
    localparam int         DEBT_W   = 2;
    localparam logic [1:0] DEBT_MAX = 2'd3;

    // A byte_we of all ones is the only write that skips the read phase
    localparam logic [3:0] WE_FULL = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REFRESH,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_WR_ISSUE,
        ST_WR_WAIT,
        ST_DONE
    } state_t;

    // Number of main-clock cycles between refresh requests
    function automatic int refreshCycles(input int clkHz, input int refreshUs);
        return clkHz / 1_000_000 * refreshUs;
    endfunction

    // Builds the word written back by a partial write: enabled bytes come from
    // the CPU, the rest are preserved from what the SDRAM returned
    function automatic logic [31:0] mergeBytes(input logic [3:0]  byteWe,
                                               input logic [31:0] writeData,
                                               input logic [31:0] readData);
        logic [31:0] merged;
        merged = '0;
        for (int i = 0; i < 4; i++) begin
            merged[i*8 +: 8] = byteWe[i] ? writeData[i*8 +: 8] : readData[i*8 +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/sdram_bridge_if.sv
// ---------------------------------------------------------------------------
// sdram_bridge_if
// Bus bundles on either side of the bridge.
//
// sdram_bridge_mem_if : SoC memory bus.
//   master (CPU)    drives select, address[31:2], byteWe, dataWrite
//                   receives dataRead, pause, dataReady
//   slave  (bridge) the opposite directions
//
// sdram_bridge_cmd_if : SDRAM controller command interface.
//   master (bridge) drives cmdRead, cmdWrite, cmdRefresh, address, dataIn
//                   receives dataOut, dataReady, busy
//   slave  (sdram)  the opposite directions
// ---------------------------------------------------------------------------
interface sdram_bridge_mem_if;
    logic        select;
    logic [31:2] address;
    logic [3:0]  byteWe;
    logic [31:0] dataWrite;
    logic [31:0] dataRead;
    logic        pause;
    logic        dataReady;

    modport master (
        output select, address, byteWe, dataWrite,
        input  dataRead, pause, dataReady
    );

    modport slave (
        input  select, address, byteWe, dataWrite,
        output dataRead, pause, dataReady
    );
endinterface

interface sdram_bridge_cmd_if
    import sdram_bridge_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
);
    logic              cmdRead;
    logic              cmdWrite;
    logic              cmdRefresh;
    logic [ADDR_W-1:0] address;
    logic [31:0]       dataIn;
    logic [31:0]       dataOut;
    logic              dataReady;
    logic              busy;

    modport master (
        output cmdRead, cmdWrite, cmdRefresh, address, dataIn,
        input  dataOut, dataReady, busy
    );

    modport slave (
        input  cmdRead, cmdWrite, cmdRefresh, address, dataIn,
        output dataOut, dataReady, busy
    );
endinterface

// File: rtl/sdram_bridge_refresh_timer.sv
// ---------------------------------------------------------------------------
// sdram_bridge_refresh_timer
// Free-running refresh interval counter plus the outstanding-refresh debt.
// Every expiry adds one refresh owed; every refresh the bridge issues pays one
// back. Debt saturates at DEBT_MAX and an expiry that finds it saturated sets
// a sticky overrun flag.
//
// Ports:
//   i_clk            main clock
//   i_rst            synchronous active-high reset
//   i_refreshIssue   bridge is issuing a refresh command this cycle
//   o_debt           refreshes currently owed
//   o_overrun        sticky: an expiry was lost because debt was saturated
// ---------------------------------------------------------------------------
module sdram_bridge_refresh_timer
    import sdram_bridge_pkg::*;
#(
    parameter int REFRESH_CYCLES = 720
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_refreshIssue,
    output logic [DEBT_W-1:0] o_debt,
    output logic              o_overrun
);

    localparam int               CNT_W  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(REFRESH_CYCLES - 1);

    logic [CNT_W-1:0]  r_count;
    logic [DEBT_W-1:0] r_debt;
    logic              r_overrun;
    logic              w_expire;

    assign w_expire  = (r_count == '0);
    assign o_debt    = r_debt;
    assign o_overrun = r_overrun;

    // The counter runs REFRESH_CYCLES-1 down to 0 and reloads, so one expiry
    // happens every REFRESH_CYCLES clocks regardless of bus activity.
    // An expiry and an issued refresh in the same cycle cancel each other,
    // which keeps the debt unchanged and cannot trigger an overrun.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count   <= RELOAD;
            r_debt    <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_count <= w_expire ? RELOAD : (r_count - CNT_W'(1));

            if (w_expire && !i_refreshIssue) begin
                if (r_debt == DEBT_MAX) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_debt <= r_debt + DEBT_W'(1);
                end
            end else if (!w_expire && i_refreshIssue && (r_debt != '0)) begin
                r_debt <= r_debt - DEBT_W'(1);
            end
        end
    end

endmodule

// File: rtl/sdram_bridge.sv
// ---------------------------------------------------------------------------
// sdram_bridge
// CPU-side initiator for the SDRAM controller. Accepts SoC memory bus
// requests, stalls the CPU while the request is in flight, issues single-cycle
// read/write/refresh commands only while the controller is idle, keeps up
// with periodic refresh and turns partial writes into read-modify-write.
//
// Ports:
//   i_clk             main clock, single clock domain
//   i_rst             synchronous active-high reset
//   memBus            SoC memory bus (slave side of sdram_bridge_mem_if)
//                       select/address/byteWe/dataWrite in, CPU holds them
//                       while pause is high; dataRead/dataReady valid in the
//                       DONE cycle; pause stalls the CPU
//   sdramBus          SDRAM command bus (master side of sdram_bridge_cmd_if)
//                       cmdRead/cmdWrite/cmdRefresh one-cycle pulses,
//                       address latched word address, dataIn write data,
//                       dataOut/dataReady read return, busy controller busy
//   o_refreshOverrun  sticky: refresh debt saturated and an interval was lost
// ---------------------------------------------------------------------------
module sdram_bridge
    import sdram_bridge_pkg::*;
#(
    parameter int CLK_HZ     = CLK_HZ_DEFAULT,
    parameter int REFRESH_US = REFRESH_US_DEFAULT,
    parameter int ADDR_W     = ADDR_W_DEFAULT
) (
    input  logic                i_clk,
    input  logic                i_rst,
    sdram_bridge_mem_if.slave   memBus,
    sdram_bridge_cmd_if.master  sdramBus,
    output logic                o_refreshOverrun
);

    localparam int REFRESH_CYCLES = refreshCycles(CLK_HZ, REFRESH_US);

    state_t            r_state;
    logic              r_cmdRead;
    logic              r_cmdWrite;
    logic              r_cmdRefresh;
    logic [ADDR_W-1:0] r_address;
    logic [3:0]        r_byteWe;
    logic [31:0]       r_dataIn;
    logic [31:0]       r_readData;
    logic              r_dataReady;
    logic              r_busySeen;

    logic [DEBT_W-1:0] w_debt;
    logic              w_debtPending;
    logic              w_refreshIssue;
    logic              w_overrun;

    assign w_debtPending = (w_debt != '0);

    // Refresh wins over a waiting CPU request, but only from IDLE, so an
    // in-flight read-modify-write is never split by a refresh
    assign w_refreshIssue = (r_state == ST_IDLE) && w_debtPending && !sdramBus.busy;

    sdram_bridge_refresh_timer #(
        .REFRESH_CYCLES (REFRESH_CYCLES)
    ) u_refreshTimer (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_refreshIssue (w_refreshIssue),
        .o_debt         (w_debt),
        .o_overrun      (w_overrun)
    );

    // CPU sees the stall from the very first select cycle and is released
    // only during the single DONE cycle
    assign memBus.pause     = memBus.select && (r_state != ST_DONE);
    assign memBus.dataRead  = r_readData;
    assign memBus.dataReady = r_dataReady;

    assign sdramBus.cmdRead    = r_cmdRead;
    assign sdramBus.cmdWrite   = r_cmdWrite;
    assign sdramBus.cmdRefresh = r_cmdRefresh;
    assign sdramBus.address    = r_address;
    assign sdramBus.dataIn     = r_dataIn;

    assign o_refreshOverrun = w_overrun;

    // Address bits above the SDRAM word address simply alias onto it
    generate
        if (ADDR_W < 30) begin : g_unusedAddr
            logic w_unusedAddrBits;
            assign w_unusedAddrBits = ^memBus.address[31:ADDR_W+2];
        end
    endgenerate

    // Bridge FSM. Command strobes and the CPU data-ready flag are cleared by
    // default every cycle, so any state that sets one produces exactly a
    // one-cycle pulse. A command is only set on an edge where busy was
    // sampled low, so nothing is ever issued to a busy controller.
    // For write and refresh completion the controller must first be seen
    // busy and then idle again; r_busySeen remembers the first half.
    // r_dataIn holds the CPU write data until a partial write's read returns,
    // at which point it is replaced by the merged word.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_cmdRead    <= 1'b0;
            r_cmdWrite   <= 1'b0;
            r_cmdRefresh <= 1'b0;
            r_address    <= '0;
            r_byteWe     <= '0;
            r_dataIn     <= '0;
            r_readData   <= '0;
            r_dataReady  <= 1'b0;
            r_busySeen   <= 1'b0;
        end else begin
            r_cmdRead    <= 1'b0;
            r_cmdWrite   <= 1'b0;
            r_cmdRefresh <= 1'b0;
            r_dataReady  <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_refreshIssue) begin
                        r_cmdRefresh <= 1'b1;
                        r_busySeen   <= 1'b0;
                        r_state      <= ST_REFRESH;
                    end else if (memBus.select && !sdramBus.busy) begin
                        r_address <= memBus.address[ADDR_W+1:2];
                        r_byteWe  <= memBus.byteWe;
                        r_dataIn  <= memBus.dataWrite;
                        if (memBus.byteWe == WE_FULL) begin
                            r_state <= ST_WR_ISSUE;
                        end else begin
                            r_state <= ST_RD_ISSUE;
                        end
                    end
                end

                ST_REFRESH: begin
                    if (sdramBus.busy) begin
                        r_busySeen <= 1'b1;
                    end else if (r_busySeen) begin
                        r_state <= ST_IDLE;
                    end
                end

                ST_RD_ISSUE: begin
                    if (!sdramBus.busy) begin
                        r_cmdRead <= 1'b1;
                        r_state   <= ST_RD_WAIT;
                    end
                end

                ST_RD_WAIT: begin
                    if (sdramBus.dataReady) begin
                        r_readData <= sdramBus.dataOut;
                        if (r_byteWe == 4'h0) begin
                            r_dataReady <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_dataIn <= mergeBytes(r_byteWe, r_dataIn, sdramBus.dataOut);
                            r_state  <= ST_WR_ISSUE;
                        end
                    end
                end

                ST_WR_ISSUE: begin
                    if (!sdramBus.busy) begin
                        r_cmdWrite <= 1'b1;
                        r_busySeen <= 1'b0;
                        r_state    <= ST_WR_WAIT;
                    end
                end

                ST_WR_WAIT: begin
                    if (sdramBus.busy) begin
                        r_busySeen <= 1'b1;
                    end else if (r_busySeen) begin
                        r_state <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_bridge.sv
// ---------------------------------------------------------------------------
// tb_sdram_bridge
// Drives sdram_bridge from a table of CPU transactions against a behavioural
// SDRAM (busy for 4 cycles after any command, read data 5 cycles after a
// read), then runs hand-written sequences for reset, refresh priority,
// refresh overrun and reset in the middle of a read.
// ---------------------------------------------------------------------------
module tb_sdram_bridge;
    import sdram_bridge_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic overrun;
    logic forceBusy = 1'b0;
    logic modelBusy = 1'b0;

    int compCount = 0;
    int missCount = 0;

    int readCount    = 0;
    int writeCount   = 0;
    int refreshCount = 0;
    int readyPulses  = 0;
    int firstCmd     = 0;

    logic [31:0] mem [logic [22:0]];

    typedef struct {
        logic [31:0] byteAddr;
        logic [3:0]  byteWe;
        logic [31:0] writeData;
        logic [31:0] memInit;
        int          expReads;
        int          expWrites;
        int          expReadyPulses;
        logic [31:0] expRead;
        logic [22:0] expAddr;
        logic [31:0] expMem;
    } vector_t;

    localparam int NUM_VECTORS = 9;
    vector_t vecs [NUM_VECTORS];

    always #5 clk = ~clk;

    sdram_bridge_mem_if memBus();
    sdram_bridge_cmd_if #(.ADDR_W(23)) sdramBus();

    sdram_bridge dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .memBus           (memBus),
        .sdramBus         (sdramBus),
        .o_refreshOverrun (overrun)
    );

    assign sdramBus.busy = modelBusy | forceBusy;

    function automatic logic [31:0] memRead(input logic [22:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    // Behavioural SDRAM: reacts 2 ns after each rising edge so it never races
    // the DUT registers or the negedge-driven stimulus. It is deliberately not
    // reset with the bridge, so an abandoned read still returns data late.
    int busyCnt = 0;
    int rdCnt   = 0;
    logic [22:0] rdAddr = '0;
    always @(posedge clk) begin
        #2;
        sdramBus.dataReady = 1'b0;
        if (rdCnt != 0) begin
            rdCnt--;
            if (rdCnt == 0) begin
                sdramBus.dataReady = 1'b1;
                sdramBus.dataOut   = memRead(rdAddr);
            end
        end
        if (busyCnt != 0) busyCnt--;
        if (sdramBus.cmdRead) begin
            rdCnt  = 5;
            busyCnt = 4;
            rdAddr = sdramBus.address;
            readCount++;
            if (firstCmd == 0) firstCmd = 1;
        end
        if (sdramBus.cmdWrite) begin
            mem[sdramBus.address] = sdramBus.dataIn;
            busyCnt = 4;
            writeCount++;
            if (firstCmd == 0) firstCmd = 2;
        end
        if (sdramBus.cmdRefresh) begin
            busyCnt = 4;
            refreshCount++;
            if (firstCmd == 0) firstCmd = 3;
        end
        modelBusy = (busyCnt != 0);
        if (memBus.dataReady) readyPulses++;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 500000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic clearCounts();
        readCount    = 0;
        writeCount   = 0;
        refreshCount = 0;
        readyPulses  = 0;
        firstCmd     = 0;
    endtask

    task automatic idleBus();
        memBus.select    = 1'b0;
        memBus.address   = '0;
        memBus.byteWe    = '0;
        memBus.dataWrite = '0;
    endtask

    task automatic resetAssert(input logic holdBusy);
        @(negedge clk);
        rst = 1'b1;
        forceBusy = holdBusy;
        idleBus();
        repeat (2) @(negedge clk);
    endtask

    task automatic resetRelease();
        rst = 1'b0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, ".cmdRead"},    32'(sdramBus.cmdRead),    32'h0);
        checkOutput({tag, ".cmdWrite"},   32'(sdramBus.cmdWrite),   32'h0);
        checkOutput({tag, ".cmdRefresh"}, 32'(sdramBus.cmdRefresh), 32'h0);
        checkOutput({tag, ".address"},    32'(sdramBus.address),    32'h0);
        checkOutput({tag, ".dataIn"},     sdramBus.dataIn,          32'h0);
        checkOutput({tag, ".dataRead"},   memBus.dataRead,          32'h0);
        checkOutput({tag, ".dataReady"},  32'(memBus.dataReady),    32'h0);
        checkOutput({tag, ".pause"},      32'(memBus.pause),        32'h0);
        checkOutput({tag, ".overrun"},    32'(overrun),             32'h0);
    endtask

    // One CPU transaction: hold the request until pause drops, capture the
    // DONE-cycle outputs, then confirm pause is back up the cycle after
    task automatic applyStimulus(input vector_t v, output logic timedOut,
                                 output logic [31:0] readAtDone, output logic readyAtDone,
                                 output logic pauseAfter);
        @(negedge clk);
        clearCounts();
        mem[v.expAddr]   = v.memInit;
        memBus.select    = 1'b1;
        memBus.address   = v.byteAddr[31:2];
        memBus.byteWe    = v.byteWe;
        memBus.dataWrite = v.writeData;
        timedOut    = 1'b1;
        readAtDone  = '0;
        readyAtDone = 1'b0;
        for (int c = 0; c < 200 && timedOut; c++) begin
            @(negedge clk);
            if (!memBus.pause) begin
                timedOut    = 1'b0;
                readAtDone  = memBus.dataRead;
                readyAtDone = memBus.dataReady;
            end
        end
        @(negedge clk);
        pauseAfter = memBus.pause;
        idleBus();
        repeat (2) @(negedge clk);
    endtask

    task automatic runVector(input int idx, input string tag);
        logic        timedOut;
        logic [31:0] readAtDone;
        logic        readyAtDone;
        logic        pauseAfter;
        vector_t     v;
        v = vecs[idx];
        applyStimulus(v, timedOut, readAtDone, readyAtDone, pauseAfter);
        checkOutput({tag, ".timeout"},    32'(timedOut),    32'h0);
        checkOutput({tag, ".reads"},      readCount,        v.expReads);
        checkOutput({tag, ".writes"},     writeCount,       v.expWrites);
        checkOutput({tag, ".readyCount"}, readyPulses,      v.expReadyPulses);
        checkOutput({tag, ".readyAtDone"}, 32'(readyAtDone), 32'(v.expReadyPulses != 0));
        checkOutput({tag, ".pauseAfter"}, 32'(pauseAfter),  32'h1);
        checkOutput({tag, ".address"},    32'(sdramBus.address), 32'(v.expAddr));
        checkOutput({tag, ".mem"},        memRead(v.expAddr), v.expMem);
        if (v.expReadyPulses != 0)
            checkOutput({tag, ".readData"}, readAtDone, v.expRead);
        if (v.expWrites != 0)
            checkOutput({tag, ".dataIn"}, sdramBus.dataIn, v.expMem);
    endtask

    initial begin
        logic        found;
        logic        timedOut;
        logic [31:0] readAtDone;

        //            byteAddr      we     wdata         memInit       rd wr rdy expRead       expAddr      expMem
        vecs[0] = '{32'h0000_0100, 4'h0, 32'h0000_0000, 32'hDEAD_BEEF, 1, 0, 1, 32'hDEAD_BEEF, 23'h000040, 32'hDEAD_BEEF};
        vecs[1] = '{32'h0000_0204, 4'hF, 32'h1234_5678, 32'h0000_0000, 0, 1, 0, 32'h0000_0000, 23'h000081, 32'h1234_5678};
        vecs[2] = '{32'h0000_0300, 4'h5, 32'h1122_3344, 32'hAABB_CCDD, 1, 1, 0, 32'h0000_0000, 23'h0000C0, 32'hAA22_CC44};
        vecs[3] = '{32'h0000_0008, 4'h8, 32'hF0E0_D0C0, 32'h0102_0304, 1, 1, 0, 32'h0000_0000, 23'h000002, 32'hF002_0304};
        vecs[4] = '{32'h0000_0010, 4'h6, 32'h0000_0000, 32'hFFFF_FFFF, 1, 1, 0, 32'h0000_0000, 23'h000004, 32'hFF00_00FF};
        vecs[5] = '{32'h2000_0104, 4'h0, 32'h0000_0000, 32'hCAFE_F00D, 1, 0, 1, 32'hCAFE_F00D, 23'h000041, 32'hCAFE_F00D};
        vecs[6] = '{32'h01FF_FFFC, 4'h0, 32'h0000_0000, 32'h5A5A_5A5A, 1, 0, 1, 32'h5A5A_5A5A, 23'h7FFFFF, 32'h5A5A_5A5A};
        vecs[7] = '{32'h0000_0040, 4'h1, 32'hAAAA_AABB, 32'h1111_1111, 1, 1, 0, 32'h0000_0000, 23'h000010, 32'h1111_11BB};
        vecs[8] = '{32'hFFFF_FFF8, 4'hF, 32'h0F0F_0F0F, 32'h0000_0000, 0, 1, 0, 32'h0000_0000, 23'h7FFFFE, 32'h0F0F_0F0F};

        idleBus();

        $display("[TB] power-on reset");
        resetAssert(1'b0);
        checkResetOutputs("por");
        resetRelease();

        $display("[TB] table vectors");
        for (int i = 0; i < NUM_VECTORS; i++) begin
            runVector(i, $sformatf("v%0d", i));
        end

        $display("[TB] reset during read wait");
        @(negedge clk);
        clearCounts();
        mem[23'h000040]  = 32'hDEAD_BEEF;
        memBus.select    = 1'b1;
        memBus.address   = 30'h0000_0040;
        memBus.byteWe    = 4'h0;
        memBus.dataWrite = '0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (sdramBus.cmdRead) found = 1'b1;
        end
        checkOutput("midrd.cmdSeen", 32'(found), 32'h1);
        rst = 1'b1;
        idleBus();
        @(negedge clk);
        checkResetOutputs("midrd");
        resetRelease();
        clearCounts();
        repeat (12) @(negedge clk);
        checkOutput("midrd.lateReady", readyPulses, 0);
        checkOutput("midrd.cmds", readCount + writeCount, 0);
        runVector(0, "midrd.next");

        $display("[TB] refresh priority over pending read");
        resetAssert(1'b1);
        resetRelease();
        repeat (725) @(negedge clk);
        clearCounts();
        mem[23'h000040]  = 32'hDEAD_BEEF;
        memBus.select    = 1'b1;
        memBus.address   = 30'h0000_0040;
        memBus.byteWe    = 4'h0;
        repeat (5) @(negedge clk);
        checkOutput("prio.noCmdWhileBusy", readCount + writeCount + refreshCount, 0);
        forceBusy = 1'b0;
        timedOut   = 1'b1;
        readAtDone = '0;
        for (int c = 0; c < 100 && timedOut; c++) begin
            @(negedge clk);
            if (!memBus.pause) begin
                timedOut   = 1'b0;
                readAtDone = memBus.dataRead;
            end
        end
        idleBus();
        checkOutput("prio.timeout",   32'(timedOut), 32'h0);
        checkOutput("prio.firstCmd",  firstCmd,      3);
        checkOutput("prio.refreshes", refreshCount,  1);
        checkOutput("prio.reads",     readCount,     1);
        checkOutput("prio.readData",  readAtDone,    32'hDEAD_BEEF);
        repeat (3) @(negedge clk);

        $display("[TB] refresh overrun");
        resetAssert(1'b1);
        resetRelease();
        repeat (2870) @(negedge clk);
        checkOutput("ovr.beforeFourth", 32'(overrun), 32'h0);
        repeat (15) @(negedge clk);
        checkOutput("ovr.afterFourth", 32'(overrun), 32'h1);
        clearCounts();
        forceBusy = 1'b0;
        repeat (60) @(negedge clk);
        checkOutput("ovr.refreshes", refreshCount, 3);
        checkOutput("ovr.cpuCmds",   readCount + writeCount, 0);
        checkOutput("ovr.sticky",    32'(overrun), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", compCount, missCount);
        $finish;
    end

endmodule
